f_fetch_stage: RTL and testbench
================================

// Module: f_fetch_stage
// PURPOSE
//  Fetch stage of the 5-stage MIPS pipeline. Owns the PC register, issues instruction-memory requests
//  (variable latency, ready handshake), buffers a fetched word while the front end is stalled, and drives
//  the F/D pipeline register (D_PC, D_Instr, D_ExcCode). Consumes NPC from D_NPC; its F_PC/D_PC feed it back.
// PARAMETERS
//  PC_RESET  32'h0000_3000  PC value after reset
//  IM_BASE   32'h0000_3000  lowest legal instruction address
//  IM_WORDS  4096           number of legal instruction words from IM_BASE
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-high reset
//  NPC          in   32  next PC from D_NPC (already holds F_PC when stalled)
//  stall        in   1   data-hazard stall from hazard unit; must not depend combinationally on fetch_busy
//  flush        in   1   redirect: discard in-flight fetch, bubble F/D
//  flush_pc     in   32  PC loaded on flush
//  i_inst_req   out  1   instruction request valid
//  i_inst_addr  out  32  request address (= F_PC)
//  i_inst_ready in   1   i_inst_rdata valid for i_inst_addr this cycle
//  i_inst_rdata in   32  instruction word
//  F_PC         out  32  current fetch PC
//  fetch_busy   out  1   request outstanding, not yet ready; hazard unit freezes F and D on it
//  D_PC         out  32  F/D register: PC of instruction in D
//  D_Instr      out  32  F/D register: instruction in D (0 = nop/bubble)
//  D_ExcCode    out  5   F/D register: 0 none, 5'd4 AdEL (fetch address error)
// BEHAVIOUR
//  Reset (async, immediate): F_PC=PC_RESET; D_PC=0; D_Instr=0; D_ExcCode=0; state=S_REQ; buffer=0.
//  pc_bad = F_PC[1:0]!=0 | F_PC<IM_BASE | F_PC>=IM_BASE+4*IM_WORDS (compare in 33 bits, no wrap).
//  States:
//   S_REQ : i_inst_req = !pc_bad. done = pc_bad | i_inst_ready. word = pc_bad ? 0 : i_inst_rdata,
//           exc = pc_bad ? 4 : 0.
//           done & !stall -> F/D<= {F_PC,word,exc}; F_PC<=NPC; stay S_REQ (1 instr/cycle at zero wait).
//           done & stall  -> buffer<= {word,exc}; go S_HOLD; F_PC, F/D hold.
//           !done         -> hold all; fetch_busy=1.
//   S_HOLD: i_inst_req=0, fetch_busy=0. !stall -> F/D<= {F_PC,buffer}; F_PC<=NPC; go S_REQ. stall -> hold.
//  fetch_busy = (state==S_REQ) & !pc_bad & !i_inst_ready (combinational). F/D never takes a bubble on
//   busy: holding D preserves a branch in D and its delay-slot ordering.
//  Flush (sync, highest priority over stall/busy/ready): F_PC<=flush_pc; D_PC<=flush_pc; D_Instr<=0;
//   D_ExcCode<=0; state<=S_REQ; buffered/coincident ready data discarded.
//  Memory contract: i_inst_ready refers to the address presented in the same cycle; an address change
//   abandons the request. i_inst_addr = F_PC at all times, also when i_inst_req=0.
//  AdEL fetch never touches memory, completes in the same cycle, enters D as nop with D_ExcCode=4.
//  No PC arithmetic here; PC+4 and branch targets come from NPC. Reset mid-wait: request drops at once.
// TESTING
//  1 Zero-wait stream, ready=1, stall=0, NPC=F_PC+4 -> F_PC 0x3000,0x3004,0x3008; D_PC lags F_PC by one cycle.
//  2 ready low 3 cycles at F_PC=0x3004 -> fetch_busy=1 for 3 cycles, F_PC/D hold; 4th cycle D_Instr=rdata.
//  3 ready=1 with stall=1 for 2 cycles -> state S_HOLD, i_inst_req=0; stall drop -> D_Instr=buffered word,
//    F_PC<=NPC, no refetch.
//  4 NPC=0x3002 -> next cycle i_inst_req=0, fetch_busy=0; following edge D_Instr=0, D_ExcCode=4, D_PC=0x3002.
//  5 flush with flush_pc=0x4180 during busy wait (ready same cycle) -> F_PC=0x4180, D_Instr=0, data dropped.
//  6 reset asserted mid-wait -> outputs return to reset values without a clock edge; F_PC=0x3000 after release.

Source files
------------

// File: rtl/f_fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory request,
// stall buffer and the F/D pipeline register.
module f_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        i_inst_req,
    output logic [31:0] i_inst_addr,
    input  logic        i_inst_ready,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_PC,
    output logic        fetch_busy,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [4:0]  D_ExcCode
);

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [32:0] IM_LO    = {1'b0, IM_BASE};
    localparam logic [32:0] IM_LIMIT = IM_LO + (33'(IM_WORDS) * 33'd4);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_bufInstr;
    logic [4:0]  r_bufExc;
    logic [31:0] r_dPc;
    logic [31:0] r_dInstr;
    logic [4:0]  r_dExc;

    logic [32:0] w_pcExt;
    logic        w_pcBad;
    logic        w_done;
    logic [31:0] w_word;
    logic [4:0]  w_exc;

    // Address range test is done in 33 bits so the upper bound never wraps.
    assign w_pcExt = {1'b0, r_pc};
    assign w_pcBad = (r_pc[1:0] != 2'b00) | (w_pcExt < IM_LO) | (w_pcExt >= IM_LIMIT);
    assign w_done  = w_pcBad | i_inst_ready;
    assign w_word  = w_pcBad ? 32'd0 : i_inst_rdata;
    assign w_exc   = w_pcBad ? EXC_ADEL : EXC_NONE;

    assign i_inst_req  = (r_state == S_REQ) & ~w_pcBad;
    assign i_inst_addr = r_pc;
    assign fetch_busy  = (r_state == S_REQ) & ~w_pcBad & ~i_inst_ready;
    assign F_PC        = r_pc;
    assign D_PC        = r_dPc;
    assign D_Instr     = r_dInstr;
    assign D_ExcCode   = r_dExc;

    // D is never bubbled while busy so a branch in D keeps its delay slot in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= PC_RESET;
            r_bufInstr <= 32'd0;
            r_bufExc   <= EXC_NONE;
            r_dPc      <= 32'd0;
            r_dInstr   <= 32'd0;
            r_dExc     <= EXC_NONE;
        end else if (flush) begin
            r_state    <= S_REQ;
            r_pc       <= flush_pc;
            r_bufInstr <= 32'd0;
            r_bufExc   <= EXC_NONE;
            r_dPc      <= flush_pc;
            r_dInstr   <= 32'd0;
            r_dExc     <= EXC_NONE;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_done && !stall) begin
                        r_dPc    <= r_pc;
                        r_dInstr <= w_word;
                        r_dExc   <= w_exc;
                        r_pc     <= NPC;
                    end else if (w_done) begin
                        r_bufInstr <= w_word;
                        r_bufExc   <= w_exc;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_dPc    <= r_pc;
                        r_dInstr <= r_bufInstr;
                        r_dExc   <= r_bufExc;
                        r_pc     <= NPC;
                        r_state  <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_f_fetch_stage.sv
// Scoreboard bench for f_fetch_stage: directed per-cycle stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_f_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] NPC;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        i_inst_req;
    logic [31:0] i_inst_addr;
    logic        i_inst_ready;
    logic [31:0] i_inst_rdata;
    logic [31:0] F_PC;
    logic        fetch_busy;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [4:0]  D_ExcCode;

    typedef struct {
        string       tag;
        logic [31:0] fpc;
        logic [31:0] dpc;
        logic [31:0] dinstr;
        logic [4:0]  dexc;
        logic        req;
        logic        busy;
        logic        chkReq;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;

    f_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .NPC          (NPC),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .i_inst_req   (i_inst_req),
        .i_inst_addr  (i_inst_addr),
        .i_inst_ready (i_inst_ready),
        .i_inst_rdata (i_inst_rdata),
        .F_PC         (F_PC),
        .fetch_busy   (fetch_busy),
        .D_PC         (D_PC),
        .D_Instr      (D_Instr),
        .D_ExcCode    (D_ExcCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput({e.tag, ".F_PC"},      F_PC,        e.fpc);
            checkOutput({e.tag, ".addr"},      i_inst_addr, e.fpc);
            checkOutput({e.tag, ".D_PC"},      D_PC,        e.dpc);
            checkOutput({e.tag, ".D_Instr"},   D_Instr,     e.dinstr);
            checkOutput({e.tag, ".D_ExcCode"}, 32'(D_ExcCode), 32'(e.dexc));
            if (e.chkReq) begin
                checkOutput({e.tag, ".req"},  32'(i_inst_req), 32'(e.req));
                checkOutput({e.tag, ".busy"}, 32'(fetch_busy),  32'(e.busy));
            end
        end
    end

    task automatic applyStimulus(
        input string       tag,
        input logic        rst,
        input logic [31:0] npc,
        input logic        stl,
        input logic        fl,
        input logic [31:0] flPc,
        input logic        rdy,
        input logic [31:0] rdata,
        input logic [31:0] eFpc,
        input logic [31:0] eDpc,
        input logic [31:0] eDinstr,
        input logic [4:0]  eDexc,
        input logic        eReq,
        input logic        eBusy,
        input logic        eChkReq
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        NPC          = npc;
        stall        = stl;
        flush        = fl;
        flush_pc     = flPc;
        i_inst_ready = rdy;
        i_inst_rdata = rdata;
        e.tag = tag; e.fpc = eFpc; e.dpc = eDpc; e.dinstr = eDinstr; e.dexc = eDexc;
        e.req = eReq; e.busy = eBusy; e.chkReq = eChkReq;
        expQ.push_back(e);
    endtask

    initial begin
        reset = 1'b1; NPC = 32'd0; stall = 1'b0; flush = 1'b0; flush_pc = 32'd0;
        i_inst_ready = 1'b0; i_inst_rdata = 32'd0;
        repeat (2) @(posedge clk);

        //             tag      rst  NPC           stl  fl   flush_pc      rdy  rdata          F_PC          D_PC          D_Instr       exc  req  busy chk
        applyStimulus("z0",     0, 32'h3004,     0,  0, 32'h0,        1, 32'hAAAA0001, 32'h3000, 32'h0,    32'h0,        0,   1,   0,   1);
        applyStimulus("w1",     0, 32'h3008,     0,  0, 32'h0,        0, 32'h0,        32'h3004, 32'h3000, 32'hAAAA0001, 0,   1,   1,   1);
        applyStimulus("w2",     0, 32'h3008,     0,  0, 32'h0,        0, 32'h0,        32'h3004, 32'h3000, 32'hAAAA0001, 0,   1,   1,   1);
        applyStimulus("w3",     0, 32'h3008,     0,  0, 32'h0,        0, 32'h0,        32'h3004, 32'h3000, 32'hAAAA0001, 0,   1,   1,   1);
        applyStimulus("w4",     0, 32'h3008,     0,  0, 32'h0,        1, 32'hAAAA0002, 32'h3004, 32'h3000, 32'hAAAA0001, 0,   1,   0,   1);
        applyStimulus("s1",     0, 32'h300C,     1,  0, 32'h0,        1, 32'hAAAA0003, 32'h3008, 32'h3004, 32'hAAAA0002, 0,   1,   0,   1);
        applyStimulus("s2",     0, 32'h300C,     1,  0, 32'h0,        1, 32'hDEAD0000, 32'h3008, 32'h3004, 32'hAAAA0002, 0,   0,   0,   1);
        applyStimulus("s3",     0, 32'h300C,     0,  0, 32'h0,        0, 32'h0,        32'h3008, 32'h3004, 32'hAAAA0002, 0,   0,   0,   1);
        applyStimulus("a1",     0, 32'h3002,     0,  0, 32'h0,        1, 32'hAAAA0004, 32'h300C, 32'h3008, 32'hAAAA0003, 0,   1,   0,   1);
        applyStimulus("a2",     0, 32'h3006,     0,  0, 32'h0,        1, 32'hBBBB0000, 32'h3002, 32'h300C, 32'hAAAA0004, 0,   0,   0,   1);
        applyStimulus("a3",     0, 32'h3010,     0,  0, 32'h0,        0, 32'h0,        32'h3006, 32'h3002, 32'h0,        4,   0,   0,   1);
        applyStimulus("f1",     0, 32'h3014,     0,  0, 32'h0,        0, 32'h0,        32'h3010, 32'h3006, 32'h0,        4,   1,   1,   1);
        applyStimulus("f2",     0, 32'h3014,     1,  1, 32'h4180,     1, 32'hCCCC0001, 32'h3010, 32'h3006, 32'h0,        4,   1,   0,   1);
        applyStimulus("f3",     0, 32'h4184,     0,  0, 32'h0,        1, 32'hCCCC0002, 32'h4180, 32'h4180, 32'h0,        0,   1,   0,   1);
        applyStimulus("b1",     0, 32'h4188,     0,  1, 32'h6FFC,     1, 32'hCCCC0003, 32'h4184, 32'h4180, 32'hCCCC0002, 0,   1,   0,   1);
        applyStimulus("b2",     0, 32'h7000,     0,  0, 32'h0,        1, 32'hEEEE0001, 32'h6FFC, 32'h6FFC, 32'h0,        0,   1,   0,   1);
        applyStimulus("b3",     0, 32'h7004,     0,  0, 32'h0,        0, 32'h0,        32'h7000, 32'h6FFC, 32'hEEEE0001, 0,   0,   0,   1);
        applyStimulus("b4",     0, 32'h0,        0,  1, 32'h2FFC,     0, 32'h0,        32'h7004, 32'h7000, 32'h0,        4,   0,   0,   1);
        applyStimulus("b5",     0, 32'h3004,     0,  0, 32'h0,        1, 32'hFFFF0000, 32'h2FFC, 32'h2FFC, 32'h0,        0,   0,   0,   1);
        applyStimulus("r1",     0, 32'h3008,     0,  0, 32'h0,        0, 32'h0,        32'h3004, 32'h2FFC, 32'h0,        4,   1,   1,   1);
        applyStimulus("r2",     0, 32'h3008,     1,  0, 32'h0,        0, 32'h0,        32'h3004, 32'h2FFC, 32'h0,        4,   1,   1,   1);
        applyStimulus("rst",    1, 32'h3008,     0,  0, 32'h0,        0, 32'h0,        32'h3000, 32'h0,    32'h0,        0,   0,   0,   0);
        applyStimulus("r3",     0, 32'h3004,     0,  0, 32'h0,        1, 32'h12345678, 32'h3000, 32'h0,    32'h0,        0,   1,   0,   1);
        applyStimulus("r4",     0, 32'h3008,     0,  0, 32'h0,        0, 32'h0,        32'h3004, 32'h3000, 32'h12345678, 0,   1,   1,   1);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (expQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
